clk_en_gen: RTL
===============

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of output channels, legal range 1..8.
REQ-002 SHALL have parameter DIV_W, default 16: width of the divisor and phase fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024: settle cycles after pll_locked rises, legal range 1..65535.
REQ-004 SHALL have parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset.
REQ-005 SHALL have port refclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: upstream PLL lock, already synchronous to refclk.
REQ-008 SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-009 SHALL have port cfg_ready, output, 1 bit: a configuration request can be accepted.
REQ-010 SHALL have port cfg_ch, input, 3 bits: target channel index.
REQ-011 SHALL have port cfg_div, input, DIV_W bits: new divisor; 0 disables the channel.
REQ-012 SHALL have port cfg_phase, input, DIV_W bits: counter start offset.
REQ-013 SHALL have port tick, output, NUM_CH bits: one-cycle enable pulse per channel.
REQ-014 SHALL have port clk_out, output, NUM_CH bits: divided square wave per channel.
REQ-015 SHALL have port locked, output, 1 bit: outputs valid and running.

Function
REQ-016 SHALL implement FSM states WAIT, SETTLE and RUN, with reset state WAIT.
REQ-017 SHALL transition WAIT->SETTLE when pll_locked=1 and load the settle counter with LOCK_CYCLES-1.
REQ-018 SHALL decrement the settle counter each SETTLE cycle and transition SETTLE->RUN on the cycle the counter is 0.
REQ-019 SHALL transition from any state to WAIT on the next edge when pll_locked=0, aborting any settle count.
REQ-020 SHALL drive locked as a registered output equal to 1 exactly when state is RUN.
REQ-021 SHALL hold each channel counter at its effective phase outside RUN; tick=0 and clk_out=0 outside RUN.
REQ-022 SHALL give each channel a counter c in 0..D-1 where D is its active divisor; in RUN cycle k (k=0 first RUN cycle), c=(P+k) mod D.
REQ-023 SHALL set effective phase P=cfg_phase when cfg_phase<D, else 0.
REQ-024 SHALL register tick[i] and clk_out[i] from c of the previous cycle: tick=(c==D-1); clk_out=(c<ceil(D/2)).
REQ-025 SHALL, for D=1, assert tick every cycle and hold clk_out=1; for D=0, force tick=0, clk_out=0 and hold the counter at 0.
REQ-026 SHALL accept a configuration on a rising edge where cfg_valid=1 and cfg_ready=1, registering channel, divisor and phase into one pending slot.
REQ-027 SHALL hold cfg_ready=0 while the pending slot is full and 1 otherwise, including in WAIT and SETTLE.
REQ-028 SHALL ignore a request with cfg_ch>=NUM_CH and not write the pending slot, while still completing the handshake.
REQ-029 SHALL, in RUN, apply a pending update in the target channel's wrap cycle (c==D-1) so the next c=new P, without glitches.
REQ-030 SHALL apply a pending update immediately when the target channel has D=0 or state is not RUN, re-phasing that channel.
REQ-031 SHALL free the pending slot in the cycle the update is applied, so cfg_ready=1 on the following cycle.
REQ-032 SHALL keep a pending update pending, and apply it per REQ-030, when pll_locked drops while the update is pending.
REQ-033 SHALL have all channels that re-enter RUN together restart from their phases in the same cycle, so equal-phase channels stay aligned.

Reset
REQ-034 SHALL, while rst=1, set state=WAIT, every divisor=DEFAULT_DIV, every phase=0, counters=0, pending slot empty, tick=0, clk_out=0, locked=0, cfg_ready=1.
REQ-035 SHALL be asynchronous on assertion; on release, with pll_locked=1, SETTLE is entered on the first edge after release.

Verification
REQ-036 SHALL cover lock-up: LOCK_CYCLES=8, pll_locked=1 after reset -> locked rises 9 edges after release; ch0 (D=2) clk_out toggles every cycle.
REQ-037 SHALL cover reconfiguration: in RUN, write ch1 div=4 phase=0 -> applied at old wrap; then tick[1] every 4 cycles, clk_out[1] 1,1,0,0; no runt pulse.
REQ-038 SHALL cover handshake: two back-to-back cfg_valid requests -> second stalls with cfg_ready=0 until the first applies; ch>=NUM_CH accepted and dropped.
REQ-039 SHALL cover lock loss: pll_locked drops mid-RUN -> next edge locked=0, outputs 0; relock -> full LOCK_CYCLES settle and all channels realigned at their phases.
REQ-040 SHALL cover edge divisors: div=0 -> channel silent; div=1 -> tick every cycle; div=3 phase=5 -> phase treated as 0, clk_out 1,1,0.
REQ-041 SHALL cover reset mid-SETTLE with a pending update -> all outputs at REQ-034 values and the pending update discarded.

Source files
------------

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_gen
// Description : Multi-channel clock-enable generator. After the upstream PLL
//               reports lock and a fixed settle period elapses, each channel
//               produces a one-cycle tick and a divided square wave. Channels
//               are reconfigured through a single-slot valid/ready port. In
//               RUN, updates are applied at the channel wrap so the output
//               never shows a runt pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam logic [1:0]       c_WAIT        = 2'd0;
    localparam logic [1:0]       c_SETTLE      = 2'd1;
    localparam logic [1:0]       c_RUN         = 2'd2;
    localparam logic [15:0]      c_SETTLE_LOAD = 16'(LOCK_CYCLES - 1);
    localparam logic [3:0]       c_NUM_CH      = 4'(NUM_CH);
    localparam logic [DIV_W-1:0] c_DEF_DIV     = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [15:0]       r_settle;
    logic              r_locked;

    logic              r_pend_valid;
    logic [2:0]        r_pend_ch;
    logic [DIV_W-1:0]  r_pend_div;
    logic [DIV_W-1:0]  r_pend_phase;

    logic              w_running;
    logic              w_run_adv;
    logic              w_accept;
    logic              w_ch_ok;
    logic [DIV_W-1:0]  w_cfg_phase_eff;
    logic [NUM_CH-1:0] w_apply;

    // Channels advance only while RUN is held; the cycle that leaves RUN
    // already loads the phase and zeroes the outputs.
    assign w_running = (r_state == c_RUN);
    assign w_run_adv = w_running && pll_locked;

    // Next-state decode; losing PLL lock overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT:   if (pll_locked) w_state_nxt = c_SETTLE;
            c_SETTLE: if (r_settle == '0) w_state_nxt = c_RUN;
            c_RUN:    w_state_nxt = c_RUN;
            default:  w_state_nxt = c_WAIT;
        endcase
        if (!pll_locked) begin
            w_state_nxt = c_WAIT;
        end
    end

    // Lock FSM, settle countdown and registered lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state  <= c_WAIT;
            r_settle <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == c_RUN);
            if (r_state == c_WAIT && w_state_nxt == c_SETTLE) begin
                r_settle <= c_SETTLE_LOAD;
            end else if (r_state == c_SETTLE && r_settle != '0) begin
                r_settle <= r_settle - 16'd1;
            end
        end
    end

    // Out-of-range channels still complete the handshake but are dropped.
    // The phase is clamped here so every stored phase is already legal.
    assign cfg_ready       = ~r_pend_valid;
    assign w_accept        = cfg_valid && cfg_ready;
    assign w_ch_ok         = ({1'b0, cfg_ch} < c_NUM_CH);
    assign w_cfg_phase_eff = (cfg_phase < cfg_div) ? cfg_phase : '0;

    // Single pending-update slot: filled on accept, freed when a channel applies it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_ch    <= '0;
            r_pend_div   <= '0;
            r_pend_phase <= '0;
        end else begin
            if (w_accept && w_ch_ok) begin
                r_pend_valid <= 1'b1;
                r_pend_ch    <= cfg_ch;
                r_pend_div   <= cfg_div;
                r_pend_phase <= w_cfg_phase_eff;
            end else if (|w_apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_phase;
        logic [DIV_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_clk;
        logic             w_zero;
        logic             w_wrap;
        logic [DIV_W-1:0] w_cnt_adv;
        logic [DIV_W-1:0] w_half;

        assign w_zero    = (r_div == '0);
        assign w_wrap    = !w_zero && (r_cnt == r_div - c_DIV_ONE);
        assign w_cnt_adv = (w_zero || w_wrap) ? '0 : r_cnt + c_DIV_ONE;
        // ceil(D/2) without needing an extra bit of headroom
        assign w_half    = (r_div >> 1) + {{(DIV_W-1){1'b0}}, r_div[0]};

        // A silent channel or a stopped generator takes the update at once;
        // a running channel waits for its wrap so the waveform stays clean.
        assign w_apply[i] = r_pend_valid && (r_pend_ch == 3'(i))
                            && (!w_running || w_zero || w_wrap);

        // Channel counter, divisor/phase registers and registered outputs.
        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_div   <= c_DEF_DIV;
                r_phase <= '0;
                r_cnt   <= '0;
                r_tick  <= 1'b0;
                r_clk   <= 1'b0;
            end else begin
                if (w_apply[i]) begin
                    r_div   <= r_pend_div;
                    r_phase <= r_pend_phase;
                    r_cnt   <= r_pend_phase;
                end else if (w_run_adv) begin
                    r_cnt   <= w_cnt_adv;
                end else begin
                    r_cnt   <= r_phase;
                end

                if (w_run_adv) begin
                    r_tick <= w_wrap;
                    r_clk  <= (r_cnt < w_half);
                end else begin
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                end
            end
        end

        assign tick[i]    = r_tick;
        assign clk_out[i] = r_clk;
    end

    assign locked = r_locked;

endmodule
`default_nettype wire
